// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - four-digit common-anode 7-segment scan controller with sequential binary-to-BCD
// Optional build macro: FND_LZ_BLANK_EN (leading-zero blanking on digits 1..3).
module fnd_scan_ctrl #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000,
    parameter int NUM_W   = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_W-1:0] number,
    output logic [3:0]       fndCom,
    output logic [7:0]       fndFont
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int CNT_W    = $clog2(SCAN_DIV);
    localparam int ITER_W   = $clog2(NUM_W + 1);
    localparam int SR_W     = NUM_W + 16;

    localparam logic [CNT_W-1:0]  SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(NUM_W - 1);
    localparam logic [NUM_W-1:0]  NUM_MAX   = NUM_W'(9999);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [NUM_W-1:0]  num_sat;
    logic [NUM_W-1:0]  last_val;
    logic [SR_W-1:0]   shift_reg;
    logic [SR_W-1:0]   adj_reg;
    logic [ITER_W-1:0] iter;
    logic [15:0]       bcd_disp;
    logic [CNT_W-1:0]  scan_cnt;
    logic [1:0]        digit_sel;
    logic [3:0]        cur_nib;
    logic              blank;

    assign num_sat = (number > NUM_MAX) ? NUM_MAX : number;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        adj_reg = shift_reg;
        for (int k = 0; k < 4; k++) begin
            if (shift_reg[NUM_W + 4*k +: 4] >= 4'd5)
                adj_reg[NUM_W + 4*k +: 4] = shift_reg[NUM_W + 4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            last_val  <= '0;
            shift_reg <= '0;
            iter      <= '0;
            bcd_disp  <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (num_sat != last_val) begin
                        last_val  <= num_sat;
                        shift_reg <= {16'b0, num_sat};
                        iter      <= '0;
                        state     <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    shift_reg <= {adj_reg[SR_W-2:0], 1'b0};
                    iter      <= iter + ITER_W'(1);
                    if (iter == ITER_LAST)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    // Only a finished conversion ever reaches the display register.
                    bcd_disp <= shift_reg[SR_W-1 -: 16];
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_sel <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_sel <= digit_sel + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + CNT_W'(1);
        end
    end

    function automatic logic [7:0] seg7(input logic [3:0] nib);
        case (nib)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    assign cur_nib = bcd_disp[{digit_sel, 2'b00} +: 4];

`ifdef FND_LZ_BLANK_EN
    // A digit is blank when it and every more-significant digit are zero; digit 0 always shows.
    always_comb begin
        case (digit_sel)
            2'd1:    blank = (bcd_disp[15:4]  == 12'h000);
            2'd2:    blank = (bcd_disp[15:8]  == 8'h00);
            2'd3:    blank = (bcd_disp[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fndCom  <= 4'b1110;
            fndFont <= 8'hC0;
        end else begin
            fndCom  <= ~(4'b0001 << digit_sel);
            fndFont <= blank ? 8'hFF : seg7(cur_nib);
        end
    end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
Four-digit common-anode 7-segment display controller. Sits downstream of the dedicated processor and consumes its binary output value.
- Converts the binary value to BCD with a sequential double-dabble engine.
- Time-multiplexes the four digits onto fndCom/fndFont.
- Runs on the fast system clock, independent of the processor's slow clock.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
SCAN_HZ, 1_000, digit-advance rate in Hz; SCAN_DIV = CLK_HZ/SCAN_HZ, must be >= 2
NUM_W, 14, width of the binary input

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
number  input  NUM_W  unsigned binary value to display; may change on any cycle
fndCom  output  4  digit enables, active-low, one-hot-low; bit0 = rightmost (ones) digit
fndFont  output  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1 (off)

Behaviour:
- Clock and reset: reset is asynchronous, active-high (rst); clock is clk. All state is async-reset, posedge clk.
- Reset values: fndCom=4'b1110, fndFont=8'hC0, digit_sel=0, scan_cnt=0, last_val=0, bcd_disp=16'h0000, FSM=IDLE.
- Saturation: num_sat = (number > 9999) ? 9999 : number. Combinational, NUM_W-bit compare.
- Conversion FSM:
  - IDLE: if num_sat != last_val, then last_val<=num_sat, shift reg <= {16'b0, num_sat}, iter<=0, go to CONV. Otherwise stay in IDLE.
  - CONV: once per cycle, add 3 to every BCD nibble >=5, then shift left 1. iter++. After the NUM_W-th shift, go to DONE.
  - DONE: bcd_disp <= BCD nibbles, go to IDLE.
- Latency: bcd_disp updates on the 16th rising edge after the IDLE edge that sampled the new value (1 load + 14 shifts + 1 commit).
- Input changes during CONV/DONE are ignored. On return to IDLE, num_sat is re-compared with last_val, so the final value always converges.
- Equal values never retrigger a conversion.
- bcd_disp holds the old value until DONE; the display never shows a partial result.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - On terminal count, digit_sel increments 0→1→2→3→0.
- Output stage: fndCom and fndFont are registered. On each edge, fndCom <= ~(4'b0001 << digit_sel) and fndFont <= seg(bcd_disp[digit_sel]), so outputs lag digit_sel by 1 cycle.
  - fndCom is always exactly one bit low; it is never all-ones after reset.
- Segment map: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Any nibble >9 (unreachable) shows FF.
- Reset mid-conversion: the FSM aborts to IDLE with all state at reset values. After rst deasserts, a non-zero number restarts conversion.

Optional Feature:
- Macro: FND_LZ_BLANK_EN
- Defined: leading-zero blanking.
  - Digit k (k=1..3) shows FF when it and all higher digits are 0.
  - Digit 0 is never blanked, so value 0 shows "   0".
  - Blank decision uses bcd_disp in the same registered output stage; latency is unchanged.
- Undefined: all four digits always driven, including leading zeros (e.g. "0007").

Test Plan:
Bench parameters: CLK_HZ=1000, SCAN_HZ=100 (SCAN_DIV=10), macro undefined unless noted.
1. Assert rst, release, hold number=0 for 50 cycles -> fndCom=1110 and fndFont=C0 immediately; FSM never leaves IDLE; digit_sel advances every 10 cycles; fndCom cycles 1110→1101→1011→0111→1110.
2. Apply number=1234 in IDLE -> bcd_disp=16'h1234 exactly 16 edges later; fndFont per digit 0..3 = 99, B0, A4, F9.
3. Apply number=16383 -> saturates to 9999; all digits show 90.
4. Apply number=5, then change to 42 at 4 cycles into CONV -> bcd_disp=0005 at edge 16, then 0042 at edge 32 (1 IDLE compare cycle plus a 16-cycle conversion). No intermediate value appears.
5. Apply number=1234, assert rst 8 cycles into CONV -> outputs return to 1110/C0 asynchronously and bcd_disp=0. After release, a new conversion completes 16 edges later.
6. With FND_LZ_BLANK_EN defined, apply number=7 -> digits 3..1 show FF, digit0 shows F8. Without the macro -> digits 3..1 show C0.
